// File: rtl/nrzi_hdlc_pkg.sv
// Shared types and constants for the NRZI/HDLC receive path.
package nrzi_hdlc_pkg;

  typedef enum logic {
    HUNT = 1'b0,
    DATA = 1'b1
  } state_t;

  localparam logic [7:0] FLAG       = 8'h7E;
  localparam logic [2:0] ONES_STUFF = 3'd5;
  localparam logic [2:0] ONES_FLAG  = 3'd6;
  localparam logic [2:0] ONES_ABORT = 3'd7;

endpackage

// File: rtl/nrzi_hdlc_rx_decode.sv
// NRZI line decoder: a line toggle means 1, a steady level means 0.
// This is the inverse of a T flip-flop driven by the data.
module nrzi_decode (
  input  logic clk,
  input  logic rst,
  input  logic din,
  input  logic din_valid,
  output logic b,
  output logic b_valid
);

  logic prev_level;

  always_ff @(posedge clk) begin
    if (rst) begin
      prev_level <= 1'b0;
    end else if (din_valid) begin
      prev_level <= din;
    end
  end

  assign b       = din ^ prev_level;
  assign b_valid = din_valid;

endmodule

// File: rtl/nrzi_hdlc_rx.sv
// HDLC deframer behind an NRZI decoder: flag/abort/stuffing detection,
// LSB-first byte assembly and registered frame strobes.
module nrzi_hdlc_rx
  import nrzi_hdlc_pkg::*;
#(
  parameter int MAX_FRAME = 256
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       din,
  input  logic       din_valid,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       frame_end,
  output logic       frame_err,
  output logic       in_frame
);

  localparam int BCW = $clog2(MAX_FRAME + 2);

  logic           b;
  logic           b_valid;
  state_t         state;
  logic [2:0]     ones;
  logic [2:0]     bit_cnt;
  logic [BCW-1:0] byte_cnt;
  logic [6:0]     shreg;
  logic [7:0]     asm_next;
  logic           is_abort;
  logic           is_flag;
  logic           shift_en;

  nrzi_decode u_decode (
    .clk       (clk),
    .rst       (rst),
    .din       (din),
    .din_valid (din_valid),
    .b         (b),
    .b_valid   (b_valid)
  );

  // shreg keeps the newest seven bits; asm_next is the byte completed by b.
  always_comb begin
    asm_next = {b, shreg};
    is_abort = b && (ones >= ONES_FLAG);
    is_flag  = !b && (ones == ONES_FLAG);
    shift_en = 1'b0;
    if (state == DATA) begin
      if (b) shift_en = (ones < ONES_FLAG);
      else   shift_en = (ones != ONES_STUFF) && (ones != ONES_FLAG);
    end
  end

  always_ff @(posedge clk) begin
    rx_valid  <= 1'b0;
    frame_end <= 1'b0;
    frame_err <= 1'b0;
    if (rst) begin
      state    <= HUNT;
      ones     <= 3'd0;
      bit_cnt  <= 3'd0;
      byte_cnt <= '0;
      shreg    <= 7'd0;
      rx_data  <= 8'd0;
    end else if (b_valid) begin
      if (b) ones <= (ones >= ONES_FLAG) ? ONES_ABORT : ones + 3'd1;
      else   ones <= 3'd0;

      if (is_abort) begin
        state     <= HUNT;
        frame_err <= (state == DATA);
      end else if (is_flag) begin
        // The closing flag's first seven bits already sit in the assembler.
        if (state == DATA) begin
          if (bit_cnt == 3'd7) frame_end <= (byte_cnt != '0);
          else                 frame_err <= 1'b1;
        end
        state    <= DATA;
        bit_cnt  <= 3'd0;
        byte_cnt <= '0;
      end else if (shift_en) begin
        shreg <= asm_next[7:1];
        if (bit_cnt == 3'd7) begin
          bit_cnt <= 3'd0;
          if (int'(byte_cnt) >= MAX_FRAME) begin
            frame_err <= 1'b1;
            state     <= HUNT;
          end else begin
            rx_data  <= asm_next;
            rx_valid <= 1'b1;
            byte_cnt <= byte_cnt + 1'b1;
          end
        end else begin
          bit_cnt <= bit_cnt + 3'd1;
        end
      end
    end
  end

  assign in_frame = (state == DATA);

endmodule

// File: tb/tb_nrzi_hdlc_rx.sv
// Directed bench for nrzi_hdlc_rx with a strobe scoreboard per DUT instance.
module tb_nrzi_hdlc_rx;
  import nrzi_hdlc_pkg::*;

  localparam logic [1:0] K_BYTE = 2'd1;
  localparam logic [1:0] K_END  = 2'd2;
  localparam logic [1:0] K_ERR  = 2'd3;

  logic       clk;
  logic       rst;
  logic       rst_b;
  logic       din;
  logic       din_valid;
  logic [7:0] rx_data_a, rx_data_b;
  logic       rx_valid_a, rx_valid_b;
  logic       frame_end_a, frame_end_b;
  logic       frame_err_a, frame_err_b;
  logic       in_frame_a, in_frame_b;

  logic [9:0] exp_a[$];
  logic [9:0] exp_b[$];
  int         checks;
  int         errors;
  logic       level;
  bit         gap_en;

  nrzi_hdlc_rx dut_a (
    .clk       (clk),
    .rst       (rst),
    .din       (din),
    .din_valid (din_valid),
    .rx_data   (rx_data_a),
    .rx_valid  (rx_valid_a),
    .frame_end (frame_end_a),
    .frame_err (frame_err_a),
    .in_frame  (in_frame_a)
  );

  nrzi_hdlc_rx #(.MAX_FRAME(2)) dut_b (
    .clk       (clk),
    .rst       (rst_b),
    .din       (din),
    .din_valid (din_valid),
    .rx_data   (rx_data_b),
    .rx_valid  (rx_valid_b),
    .frame_end (frame_end_b),
    .frame_err (frame_err_b),
    .in_frame  (in_frame_b)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // driver tasks
  task automatic idle_cycle();
    din_valid = 1'b0;
    din       = 1'($urandom_range(0, 1));
    @(posedge clk); #1;
  endtask

  task automatic send_bit(input logic bv);
    if (gap_en) repeat ($urandom_range(0, 2)) idle_cycle();
    if (bv) level = ~level;
    din       = level;
    din_valid = 1'b1;
    @(posedge clk); #1;
    din_valid = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] v);
    for (int i = 0; i < 8; i++) send_bit(v[i]);
  endtask

  task automatic send_flag();
    send_byte(FLAG);
  endtask

  task automatic drain();
    repeat (3) idle_cycle();
    check("drain_a", exp_a.size(), 0);
    check("drain_b", exp_b.size(), 0);
  endtask

  // scoreboards
  always @(negedge clk) begin
    logic [9:0] obs;
    if (!rst && (rx_valid_a || frame_end_a || frame_err_a)) begin
      check("onehot_a", $countones({rx_valid_a, frame_end_a, frame_err_a}), 1);
      obs = rx_valid_a ? {K_BYTE, rx_data_a} : frame_end_a ? {K_END, 8'h00} : {K_ERR, 8'h00};
      if (exp_a.size() == 0) check("extra_a", exp_a.size(), 1);
      else                   check("strobe_a", obs, exp_a.pop_front());
    end
  end

  always @(negedge clk) begin
    logic [9:0] obs;
    if (!rst_b && (rx_valid_b || frame_end_b || frame_err_b)) begin
      check("onehot_b", $countones({rx_valid_b, frame_end_b, frame_err_b}), 1);
      obs = rx_valid_b ? {K_BYTE, rx_data_b} : frame_end_b ? {K_END, 8'h00} : {K_ERR, 8'h00};
      if (exp_b.size() == 0) check("extra_b", exp_b.size(), 1);
      else                   check("strobe_b", obs, exp_b.pop_front());
    end
  end

  initial begin
    checks    = 0;
    errors    = 0;
    gap_en    = 1'b0;
    level     = 1'b0;
    rst       = 1'b1;
    rst_b     = 1'b1;
    din       = 1'b0;
    din_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_a", {rx_data_a, rx_valid_a, frame_end_a, frame_err_a, in_frame_a}, 0);
    rst = 1'b0;

    // basic frame
    exp_a.push_back({K_BYTE, 8'hA5});
    exp_a.push_back({K_BYTE, 8'h3C});
    exp_a.push_back({K_END, 8'h00});
    send_flag();
    check("in_frame_open", in_frame_a, 1);
    send_byte(8'hA5);
    check("latency_a5", {rx_valid_a, rx_data_a}, {1'b1, 8'hA5});
    send_byte(8'h3C);
    send_flag();
    drain();
    check("in_frame_after_end", in_frame_a, 1);

    // bit stuffing: five 1s, stuffed 0, three 1s -> 0xFF
    exp_a.push_back({K_BYTE, 8'hFF});
    exp_a.push_back({K_END, 8'h00});
    send_flag();
    for (int i = 0; i < 5; i++) send_bit(1'b1);
    send_bit(1'b0);
    for (int i = 0; i < 3; i++) send_bit(1'b1);
    send_flag();
    drain();

    // abort
    exp_a.push_back({K_BYTE, 8'h12});
    exp_a.push_back({K_ERR, 8'h00});
    send_flag();
    send_byte(8'h12);
    for (int i = 0; i < 7; i++) send_bit(1'b1);
    drain();
    check("in_frame_abort", in_frame_a, 0);
    send_flag();
    check("in_frame_reenter", in_frame_a, 1);

    // misaligned: 1,0,1 plus five flag bits complete a byte (0xF5) before the flag errors
    exp_a.push_back({K_BYTE, 8'hF5});
    exp_a.push_back({K_ERR, 8'h00});
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    send_flag();
    drain();
    repeat (3) send_flag();
    drain();
    check("in_frame_idle", in_frame_a, 1);

    // basic frame with random gaps
    gap_en = 1'b1;
    exp_a.push_back({K_BYTE, 8'hA5});
    exp_a.push_back({K_BYTE, 8'h3C});
    exp_a.push_back({K_END, 8'h00});
    send_flag();
    send_byte(8'hA5);
    send_byte(8'h3C);
    send_flag();
    gap_en = 1'b0;
    drain();

    // overlength on the MAX_FRAME=2 instance, same stream is a good frame on the other
    rst   = 1'b1;
    rst_b = 1'b1;
    @(posedge clk); #1;
    rst   = 1'b0;
    rst_b = 1'b0;
    level = 1'b0;
    exp_a.push_back({K_BYTE, 8'h11});
    exp_a.push_back({K_BYTE, 8'h22});
    exp_a.push_back({K_BYTE, 8'h5A});
    exp_a.push_back({K_END, 8'h00});
    exp_b.push_back({K_BYTE, 8'h11});
    exp_b.push_back({K_BYTE, 8'h22});
    exp_b.push_back({K_ERR, 8'h00});
    send_flag();
    send_byte(8'h11);
    send_byte(8'h22);
    send_byte(8'h5A);
    check("in_frame_overlen_b", in_frame_b, 0);
    send_flag();
    drain();
    check("in_frame_reenter_b", in_frame_b, 1);
    rst_b = 1'b1;

    // reset four bits into the second byte
    exp_a.push_back({K_BYTE, 8'hA5});
    send_flag();
    send_byte(8'hA5);
    send_bit(1'b0);
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b1);
    rst       = 1'b1;
    din_valid = 1'b1;
    din       = ~level;
    @(posedge clk); #1;
    check("reset_mid", {rx_data_a, rx_valid_a, frame_end_a, frame_err_a, in_frame_a}, 0);
    rst       = 1'b0;
    din_valid = 1'b0;
    level     = 1'b0;
    drain();
    exp_a.push_back({K_BYTE, 8'h3C});
    exp_a.push_back({K_BYTE, 8'hC3});
    exp_a.push_back({K_END, 8'h00});
    send_flag();
    send_byte(8'h3C);
    send_byte(8'hC3);
    send_flag();
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
